branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
Consumes the C/Z/N/V flags produced by the status register.
Executes 6502 relative branches (BPL/BMI/BVC/BVS/BCC/BCS/BNE/BEQ):
- evaluates the condition;
- adds the signed offset to the PC;
- inserts the page-cross fix-up cycle.

Sits between the decode/control sequencer and the PC register. It hands the PC a new value through a one-cycle load strobe and reproduces the 2/3/4-cycle branch timing.

Parameters:
- PC_W, 16, program counter width. Only the low 8 bits participate in the page add.
- PAGE_PENALTY, 1. 1 = separate FIX_HIGH cycle on page cross. 0 = high byte fixed in ADD_LOW, no extra cycle.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs
- start  in  1  begin branch; sampled only in IDLE
- cond_sel  in  3  opcode bits [7:5]: 000 BPL, 001 BMI, 010 BVC, 011 BVS, 100 BCC, 101 BCS, 110 BNE, 111 BEQ
- offset  in  8  signed two's-complement displacement
- pc_in  in  PC_W  address of the instruction following the branch
- flag_carry  in  1  C from status register
- flag_zero  in  1  Z
- flag_negative  in  1  N
- flag_overflow  in  1  V
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, branch complete
- taken  out  1  condition result; valid with done, held until next start
- pc_load  out  1  one-cycle pulse coincident with done when taken
- pc_out  out  PC_W  branch target; equals pc_in snapshot when not taken

Behaviour:
- Reset values: busy=0, done=0, taken=0, pc_load=0, pc_out=0, state=IDLE. Reset is asynchronous and takes effect mid-operation from any state; no done pulse follows.
- All outputs are registered.
- IDLE: on start=1, latch cond_sel, offset, pc_in and all four flags. Go to EVAL. Flags are snapshotted, so later flag changes do not affect the branch.
- EVAL: cond = selected flag XNOR cond_sel[0]. The flag is N/V/C/Z for cond_sel[2:1] = 00/01/10/11; cond_sel[0]=1 means branch if the flag is set.
  - Not taken: pc_out <= snapshot, taken <= 0, go to DONE.
  - Taken: taken <= 1, go to ADD_LOW.
- ADD_LOW: sum9 = {0, pc[7:0]} + {0, offset}; pc_out[7:0] <= sum9[7:0].
  - Page cross = (offset[7]=0 and sum9[8]=1) or (offset[7]=1 and sum9[8]=0).
  - No cross: pc_out high <= pc high, go to DONE.
  - Cross with PAGE_PENALTY=1: go to FIX_HIGH.
  - Cross with PAGE_PENALTY=0: apply the high-byte fix here, go to DONE.
- FIX_HIGH: pc_out[PC_W-1:8] <= pc high + 1 (forward) or − 1 (backward), modulo 2^(PC_W-8) (wraps $FF↔$00). Go to DONE.
- DONE: done=1 for one cycle; pc_load=taken for one cycle. Return to IDLE.
- Latency, start cycle t to done high: not taken t+2; taken same page t+3; taken page cross t+4 (t+3 when PAGE_PENALTY=0).
- start while busy is ignored and not queued. start in the cycle after DONE (IDLE) is accepted normally.
- offset=$00 taken: pc_out=pc_in, no cross, t+3.

Decomposition:
- Shared package cpu_pkg holds:
  - branch_cond_e enum (BPL..BEQ encodings above);
  - branch_state_e enum (IDLE, EVAL, ADD_LOW, FIX_HIGH, DONE);
  - PC_W default constant.
- One combinational sub-module, branch_cond_eval (cond_sel + four flags → taken). It is reusable by the decoder for prediction or trace.

Test Plan:
- BEQ (111), Z=1, pc_in=$1234, offset=$10, start@t → done@t+3, taken=1, pc_load=1, pc_out=$1244.
- BNE (110), Z=1, pc_in=$1234 → done@t+2, taken=0, pc_load=0, pc_out=$1234. Sweep all 8 cond_sel × flag=0/1 against branch_cond_eval.
- BCS, C=1, pc_in=$12F0, offset=$20 → done@t+4, pc_out=$1310. Backward: pc_in=$1205, offset=$F0 → done@t+4, pc_out=$11F5.
- Wrap: pc_in=$FFF0, offset=$20 → pc_out=$0010. pc_in=$0005, offset=$F0 → pc_out=$FFF5. With PAGE_PENALTY=0 both complete @t+3.
- Snapshot and ignore: BMI with N=1 at start, N→0 at t+1, second start at t+2 → branch still taken, one done only, second start ignored.
- Assert reset asynchronously during FIX_HIGH → all outputs 0 immediately, no done. A start after release completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: branch condition encodings, branch sequencer states and
// the default program counter width.
package cpu_pkg;

  localparam int PC_W_DEF = 16;

  typedef enum logic [2:0] {
    BPL = 3'b000,
    BMI = 3'b001,
    BVC = 3'b010,
    BVS = 3'b011,
    BCC = 3'b100,
    BCS = 3'b101,
    BNE = 3'b110,
    BEQ = 3'b111
  } branch_cond_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EVAL     = 3'd1,
    ADD_LOW  = 3'd2,
    FIX_HIGH = 3'd3,
    DONE     = 3'd4
  } branch_state_e;

endpackage

// File: rtl/branch_unit_if.sv
// Request/response bundle between the control sequencer and the branch unit.
interface branch_unit_if
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
);
  logic            start;
  logic [2:0]      cond_sel;
  logic [7:0]      offset;
  logic [PC_W-1:0] pc_in;
  logic            flag_carry;
  logic            flag_zero;
  logic            flag_negative;
  logic            flag_overflow;
  logic            busy;
  logic            done;
  logic            taken;
  logic            pc_load;
  logic [PC_W-1:0] pc_out;

  modport master (
    output start, cond_sel, offset, pc_in,
    output flag_carry, flag_zero, flag_negative, flag_overflow,
    input  busy, done, taken, pc_load, pc_out
  );

  modport slave (
    input  start, cond_sel, offset, pc_in,
    input  flag_carry, flag_zero, flag_negative, flag_overflow,
    output busy, done, taken, pc_load, pc_out
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Pure combinational 6502 branch condition: opcode bits [7:5] pick a flag,
// bit 5 selects whether the branch fires on the flag being set or clear.
module branch_cond_eval (
  input  logic [2:0] cond_sel,
  input  logic       flag_carry,
  input  logic       flag_zero,
  input  logic       flag_negative,
  input  logic       flag_overflow,
  output logic       taken
);
  logic flag_sel;

  always_comb begin
    case (cond_sel[2:1])
      2'b00:   flag_sel = flag_negative;
      2'b01:   flag_sel = flag_overflow;
      2'b10:   flag_sel = flag_carry;
      default: flag_sel = flag_zero;
    endcase
  end

  assign taken = ~(flag_sel ^ cond_sel[0]);
endmodule

// File: rtl/branch_unit.sv
// 6502 relative branch sequencer: snapshots the request, evaluates the
// condition, adds the offset low byte first and fixes the high byte on a page cross.
module branch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter bit PAGE_PENALTY = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  branch_unit_if.slave bus
);
  localparam int              HI_W   = PC_W - 8;
  localparam logic [HI_W-1:0] HI_ONE = HI_W'(1);

  branch_state_e   state_q, state_d;
  logic [2:0]      cond_q, cond_d;
  logic [7:0]      off_q, off_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      flags_q, flags_d;  // {N, V, C, Z}
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            taken_q, taken_d;
  logic            pc_load_q, pc_load_d;
  logic [PC_W-1:0] pc_out_q, pc_out_d;

  logic            cond_true;
  logic [8:0]      sum9;
  logic            page_cross;
  logic [HI_W-1:0] hi_fixed;

  branch_cond_eval u_cond (
    .cond_sel      (cond_q),
    .flag_carry    (flags_q[1]),
    .flag_zero     (flags_q[0]),
    .flag_negative (flags_q[3]),
    .flag_overflow (flags_q[2]),
    .taken         (cond_true)
  );

  // The carry out of the low-byte add crosses a page only when it disagrees
  // with the sign of the displacement.
  assign sum9       = {1'b0, pc_q[7:0]} + {1'b0, off_q};
  assign page_cross = off_q[7] ^ sum9[8];
  assign hi_fixed   = off_q[7] ? pc_q[PC_W-1:8] - HI_ONE : pc_q[PC_W-1:8] + HI_ONE;

  always_comb begin
    state_d  = state_q;
    cond_d   = cond_q;
    off_d    = off_q;
    pc_d     = pc_q;
    flags_d  = flags_q;
    taken_d  = taken_q;
    pc_out_d = pc_out_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cond_d  = bus.cond_sel;
          off_d   = bus.offset;
          pc_d    = bus.pc_in;
          flags_d = {bus.flag_negative, bus.flag_overflow, bus.flag_carry, bus.flag_zero};
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (cond_true) begin
          taken_d = 1'b1;
          state_d = ADD_LOW;
        end else begin
          taken_d  = 1'b0;
          pc_out_d = pc_q;
          state_d  = DONE;
        end
      end
      ADD_LOW: begin
        pc_out_d = {pc_q[PC_W-1:8], sum9[7:0]};
        state_d  = DONE;
        if (page_cross) begin
          if (PAGE_PENALTY) state_d = FIX_HIGH;
          else              pc_out_d[PC_W-1:8] = hi_fixed;
        end
      end
      FIX_HIGH: begin
        pc_out_d[PC_W-1:8] = hi_fixed;
        state_d            = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered views of the state being entered.
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    pc_load_d = done_d & taken_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cond_q    <= '0;
      off_q     <= '0;
      pc_q      <= '0;
      flags_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      pc_load_q <= 1'b0;
      pc_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cond_q    <= cond_d;
      off_q     <= off_d;
      pc_q      <= pc_d;
      flags_q   <= flags_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      taken_q   <= taken_d;
      pc_load_q <= pc_load_d;
      pc_out_q  <= pc_out_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.taken   = taken_q;
  assign bus.pc_load = pc_load_q;
  assign bus.pc_out  = pc_out_q;
endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: vector table run on both page-penalty
// variants, a condition sweep, and snapshot/ignore and async-reset sequences.
module tb_branch_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_unit_if #(.PC_W(16)) ifp ();
  branch_unit_if #(.PC_W(16)) ifz ();

  branch_unit #(.PC_W(16), .PAGE_PENALTY(1'b1)) dut_p (.clk(clk), .reset(reset), .bus(ifp));
  branch_unit #(.PC_W(16), .PAGE_PENALTY(1'b0)) dut_z (.clk(clk), .reset(reset), .bus(ifz));

  logic [2:0] ev_sel;
  logic       ev_c, ev_z, ev_n, ev_v, ev_t;
  branch_cond_eval u_ev (
    .cond_sel      (ev_sel),
    .flag_carry    (ev_c),
    .flag_zero     (ev_z),
    .flag_negative (ev_n),
    .flag_overflow (ev_v),
    .taken         (ev_t)
  );

  typedef struct {
    logic [2:0]  sel;
    logic        n, v, c, z;
    logic [7:0]  off;
    logic [15:0] pc;
    logic        exp_t;
    logic [15:0] exp_pc;
    int          lat1;
    int          lat0;
  } vec_t;

  vec_t vecs [14];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic model_cond(input logic [2:0] s, input logic n, v, c, z);
    case (s)
      BPL:     return !n;
      BMI:     return n;
      BVC:     return !v;
      BVS:     return v;
      BCC:     return !c;
      BCS:     return c;
      BNE:     return !z;
      BEQ:     return z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic st, input logic [2:0] sel, input logic n, v, c, z,
                       input logic [7:0] off, input logic [15:0] pc);
    ifp.start = st; ifp.cond_sel = sel; ifp.offset = off; ifp.pc_in = pc;
    ifp.flag_negative = n; ifp.flag_overflow = v; ifp.flag_carry = c; ifp.flag_zero = z;
    ifz.start = st; ifz.cond_sel = sel; ifz.offset = off; ifz.pc_in = pc;
    ifz.flag_negative = n; ifz.flag_overflow = v; ifz.flag_carry = c; ifz.flag_zero = z;
  endtask

  function automatic logic [19:0] outs_p();
    return {ifp.busy, ifp.done, ifp.taken, ifp.pc_load, ifp.pc_out};
  endfunction

  function automatic logic [19:0] outs_z();
    return {ifz.busy, ifz.done, ifz.taken, ifz.pc_load, ifz.pc_out};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int          lat_p, lat_z, np, nz;
    logic        tp, tz, lp, lz;
    logic [15:0] pp, pz;
    lat_p = 0; lat_z = 0; np = 0; nz = 0;
    tp = 1'b0; tz = 1'b0; lp = 1'b0; lz = 1'b0; pp = '0; pz = '0;
    @(negedge clk);
    drive(1'b1, v.sel, v.n, v.v, v.c, v.z, v.off, v.pc);
    @(posedge clk);
    #1;
    ifp.start = 1'b0; ifz.start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("v%0d_busy_p", idx), 32'(ifp.busy), 32'd1);
        chk($sformatf("v%0d_busy_z", idx), 32'(ifz.busy), 32'd1);
      end
      if (ifp.done) begin
        np++;
        if (lat_p == 0) begin lat_p = k; tp = ifp.taken; lp = ifp.pc_load; pp = ifp.pc_out; end
      end
      if (ifz.done) begin
        nz++;
        if (lat_z == 0) begin lat_z = k; tz = ifz.taken; lz = ifz.pc_load; pz = ifz.pc_out; end
      end
    end
    chk($sformatf("v%0d_lat_p", idx), 32'(lat_p), 32'(v.lat1));
    chk($sformatf("v%0d_lat_z", idx), 32'(lat_z), 32'(v.lat0));
    chk($sformatf("v%0d_ndone_p", idx), 32'(np), 32'd1);
    chk($sformatf("v%0d_ndone_z", idx), 32'(nz), 32'd1);
    chk($sformatf("v%0d_taken_p", idx), 32'(tp), 32'(v.exp_t));
    chk($sformatf("v%0d_taken_z", idx), 32'(tz), 32'(v.exp_t));
    chk($sformatf("v%0d_load_p", idx), 32'(lp), 32'(v.exp_t));
    chk($sformatf("v%0d_load_z", idx), 32'(lz), 32'(v.exp_t));
    chk($sformatf("v%0d_pc_p", idx), 32'(pp), 32'(v.exp_pc));
    chk($sformatf("v%0d_pc_z", idx), 32'(pz), 32'(v.exp_pc));
    chk($sformatf("v%0d_taken_held", idx), 32'(ifp.taken), 32'(v.exp_t));
    $display("vec %0d: sel=%0d pc_in=%h off=%h -> lat_p=%0d lat_z=%0d taken=%0d pc_out=%h",
             idx, v.sel, v.pc, v.off, lat_p, lat_z, tp, pp);
  endtask

  initial begin
    vecs[0]  = '{BEQ, 0, 0, 0, 1, 8'h10, 16'h1234, 1, 16'h1244, 3, 3};
    vecs[1]  = '{BNE, 0, 0, 0, 1, 8'h10, 16'h1234, 0, 16'h1234, 2, 2};
    vecs[2]  = '{BCS, 0, 0, 1, 0, 8'h20, 16'h12F0, 1, 16'h1310, 4, 3};
    vecs[3]  = '{BCS, 0, 0, 1, 0, 8'hF0, 16'h1205, 1, 16'h11F5, 4, 3};
    vecs[4]  = '{BCS, 0, 0, 1, 0, 8'h20, 16'hFFF0, 1, 16'h0010, 4, 3};
    vecs[5]  = '{BCS, 0, 0, 1, 0, 8'hF0, 16'h0005, 1, 16'hFFF5, 4, 3};
    vecs[6]  = '{BPL, 0, 1, 1, 1, 8'h00, 16'h2000, 1, 16'h2000, 3, 3};
    vecs[7]  = '{BMI, 0, 1, 1, 1, 8'h00, 16'h2000, 0, 16'h2000, 2, 2};
    vecs[8]  = '{BVS, 1, 1, 0, 0, 8'h7F, 16'h30FE, 1, 16'h317D, 4, 3};
    vecs[9]  = '{BVC, 1, 0, 1, 1, 8'h80, 16'h3080, 1, 16'h3000, 3, 3};
    vecs[10] = '{BCC, 1, 1, 0, 1, 8'h05, 16'h4010, 1, 16'h4015, 3, 3};
    vecs[11] = '{BNE, 1, 1, 1, 0, 8'h01, 16'h40FF, 1, 16'h4100, 4, 3};
    vecs[12] = '{BVS, 1, 0, 1, 1, 8'h40, 16'h5555, 0, 16'h5555, 2, 2};
    vecs[13] = '{BCC, 0, 0, 1, 0, 8'h40, 16'h6666, 0, 16'h6666, 2, 2};

    reset = 1'b1;
    drive(1'b0, 3'b000, 0, 0, 0, 0, 8'h00, 16'h0000);
    repeat (3) @(negedge clk);
    chk("reset_outs_p", 32'(outs_p()), 32'd0);
    chk("reset_outs_z", 32'(outs_z()), 32'd0);
    reset = 1'b0;

    // Condition sweep: the non-selected flags take the opposite value.
    for (int s = 0; s < 8; s++) begin
      for (int f = 0; f < 2; f++) begin
        ev_sel = 3'(s);
        ev_n = (ev_sel[2:1] == 2'b00) ? 1'(f) : ~1'(f);
        ev_v = (ev_sel[2:1] == 2'b01) ? 1'(f) : ~1'(f);
        ev_c = (ev_sel[2:1] == 2'b10) ? 1'(f) : ~1'(f);
        ev_z = (ev_sel[2:1] == 2'b11) ? 1'(f) : ~1'(f);
        #1;
        chk($sformatf("eval_sel%0d_f%0d", s, f), 32'(ev_t),
            32'(model_cond(ev_sel, ev_n, ev_v, ev_c, ev_z)));
        $display("eval sel=%0d flag=%0d taken=%0d", s, f, ev_t);
      end
    end

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Snapshot and ignore: N drops after start, a second start arrives while busy.
    begin
      int          nd;
      int          lat;
      logic        tk;
      logic [15:0] pc;
      nd = 0; lat = 0; tk = 1'b0; pc = '0;
      @(negedge clk);
      drive(1'b1, BMI, 1, 0, 0, 0, 8'h10, 16'h5000);
      @(posedge clk);
      #1;
      ifp.start = 1'b0; ifz.start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (ifp.done) begin
          nd++;
          if (lat == 0) begin lat = k; tk = ifp.taken; pc = ifp.pc_out; end
        end
        if (k == 1) drive(1'b0, BMI, 0, 0, 0, 0, 8'h10, 16'h5000);
        if (k == 2) drive(1'b1, BMI, 0, 0, 0, 0, 8'h20, 16'h6000);
        if (k == 3) drive(1'b0, BMI, 0, 0, 0, 0, 8'h20, 16'h6000);
      end
      chk("snap_ndone", 32'(nd), 32'd1);
      chk("snap_lat", 32'(lat), 32'd3);
      chk("snap_taken", 32'(tk), 32'd1);
      chk("snap_pc", 32'(pc), 32'h5010);
      $display("snapshot: dones=%0d lat=%0d taken=%0d pc_out=%h", nd, lat, tk, pc);
    end

    // Asynchronous reset while the penalty variant sits in FIX_HIGH.
    begin
      int nd;
      nd = 0;
      @(negedge clk);
      drive(1'b1, BCS, 0, 0, 1, 0, 8'h20, 16'h12F0);
      @(posedge clk);
      #1;
      ifp.start = 1'b0; ifz.start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (ifp.done) nd++;
        if (k == 3) begin
          #2 reset = 1'b1;
          #1;
          chk("async_reset_outs", 32'(outs_p()), 32'd0);
        end
        if (k == 5) reset = 1'b0;
      end
      chk("async_reset_nodone", 32'(nd), 32'd0);
      $display("async reset: dones after reset=%0d", nd);
    end
    run_vec(vecs[0], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
